// File: rtl/img_pkg.sv
// Shared types and sizes for the image-core request arbiter.
package img_pkg;

    localparam int COLOR_SIZE = 8;
    localparam int PIXEL_SIZE = 24;

    typedef logic [1:0] mode_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        XFER       = 2'd1,
        WAIT_CMPLT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to rr_ptr.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       gnt_id
);

    always_comb begin
        gnt_id = rr_ptr;
        if (req == 2'b01) begin
            gnt_id = 1'b0;
        end else if (req == 2'b10) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/img_req_arbiter.sv
// Burst-locked round-robin arbiter sharing one image core between two slave ports.
// Handshake: a beat moves on any cycle where slvN_data_valid and slvN_rdy are both high.
module img_req_arbiter
    import img_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            slv0_mode,
    input  logic                  slv0_data_valid,
    input  logic [7:0]            slv0_proc_val,
    input  logic [DATA_WIDTH-1:0] slv0_data,
    output logic                  slv0_rdy,
    input  logic [1:0]            slv1_mode,
    input  logic                  slv1_data_valid,
    input  logic [7:0]            slv1_proc_val,
    input  logic [DATA_WIDTH-1:0] slv1_data,
    output logic                  slv1_rdy,
    output logic [1:0]            core_mode,
    output logic [7:0]            core_proc_val,
    output logic [DATA_WIDTH-1:0] core_data,
    output logic                  core_data_valid,
    input  logic                  core_ready,
    output logic                  core_eob,
    input  logic                  core_cmplt,
    output logic                  owner,
    output logic                  busy,
    output logic                  err_cmplt
);

    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t              state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    rr_ptr_q, rr_ptr_d;
    logic                    err_q, err_d;
    mode_t                   mode_q, mode_d;
    logic [COLOR_SIZE-1:0]   pv_q, pv_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pick_id;
    logic                    own_valid;
    logic                    beat;
    logic                    last_beat;

    rr_pick2 u_pick (
        .req    ({slv1_data_valid, slv0_data_valid}),
        .rr_ptr (rr_ptr_q),
        .gnt_id (pick_id)
    );

    assign own_valid = owner_q ? slv1_data_valid : slv0_data_valid;
    assign beat      = (state_q == XFER) && own_valid && core_ready;
    assign last_beat = beat && (cnt_q == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            err_q    <= 1'b0;
            mode_q   <= '0;
            pv_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            mode_q   <= mode_d;
            pv_q     <= pv_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        mode_d   = mode_q;
        pv_d     = pv_q;
        cnt_d    = cnt_q;
        // A completion is only expected while waiting for one.
        err_d    = err_q | (core_cmplt && (state_q != WAIT_CMPLT));
        case (state_q)
            IDLE: begin
                if (slv0_data_valid || slv1_data_valid) begin
                    owner_d = pick_id;
                    mode_d  = pick_id ? slv1_mode : slv0_mode;
                    pv_d    = pick_id ? slv1_proc_val : slv0_proc_val;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (last_beat) begin
                    cnt_d   = '0;
                    state_d = WAIT_CMPLT;
                end else if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!own_valid) begin
                    // Valid dropping before any beat is a withdrawn request, not a burst.
                    if (cnt_q != '0) begin
                        cnt_d   = '0;
                        state_d = WAIT_CMPLT;
                    end else begin
                        rr_ptr_d = ~owner_q;
                        state_d  = IDLE;
                    end
                end
            end
            WAIT_CMPLT: begin
                if (core_cmplt) begin
                    rr_ptr_d = ~owner_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slv0_rdy        = 1'b0;
        slv1_rdy        = 1'b0;
        core_data_valid = 1'b0;
        core_data       = '0;
        core_eob        = 1'b0;
        if (state_q == XFER) begin
            slv0_rdy        = !owner_q && core_ready;
            slv1_rdy        = owner_q && core_ready;
            core_data_valid = own_valid;
            core_data       = owner_q ? slv1_data : slv0_data;
            core_eob        = last_beat || (!own_valid && (cnt_q != '0));
        end
    end

    assign core_mode     = mode_q;
    assign core_proc_val = pv_q;
    assign owner         = owner_q;
    assign busy          = (state_q != IDLE);
    assign err_cmplt     = err_q;

endmodule
